// File: rtl/dcache_set.sv
// rtl/dcache_set.sv - multi-way LRU data cache set with internal writeback/fill and flush sequencer
module dcache_set #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32,
  parameter int LINEBITS = 5,
  parameter int WAYS     = 2,
  parameter int BANKNUM  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] cpu_addr,
  input  logic                cpu_rdreq,
  input  logic                cpu_wrreq,
  input  logic [DATABITS-1:0] cpu_in,
  input  logic [BANKNUM-1:0]  cpu_byteenable,
  output logic [DATABITS-1:0] cpu_out,
  output logic                cpu_out_valid,
  output logic                cpu_busy,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  output logic [DATABITS-1:0] mem_out,
  input  logic [DATABITS-1:0] mem_in,
  input  logic                mem_valid,
  input  logic                flush_req,
  output logic                flush_done
);

  localparam int WORDS   = 1 << LINEBITS;
  localparam int TAGBITS = ADDRBITS - LINEBITS - 2;
  localparam int WIDX    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AW      = WIDX;
  localparam logic [LINEBITS-1:0] LAST_WORD = '1;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FLUSH, S_DONE} state_t;

  state_t              state;
  logic [LINEBITS-1:0] cnt;
  logic [WIDX-1:0]     victim;
  logic [TAGBITS-1:0]  req_tag;
  logic                flushing;
  logic [WIDX:0]       fl_scan;

  logic [TAGBITS-1:0]  tag_q   [WAYS];
  logic [AW-1:0]       age_q   [WAYS];
  logic [WAYS-1:0]     valid_q;
  logic [WAYS-1:0]     dirty_q;
  logic [DATABITS-1:0] data_q  [WAYS][WORDS];

  logic [TAGBITS-1:0]  addr_tag;
  logic [LINEBITS-1:0] addr_word;
  logic [1:0]          unused_addr_bits;
  logic                req;
  logic                hit;
  logic [WIDX-1:0]     hit_way;
  logic [WIDX-1:0]     vict_c;
  logic                vict_found;
  logic                fl_found;
  logic [WIDX-1:0]     fl_way;

  assign addr_tag         = cpu_addr[ADDRBITS-1:LINEBITS+2];
  assign addr_word        = cpu_addr[LINEBITS+1:2];
  assign unused_addr_bits = cpu_addr[1:0];
  assign req              = cpu_rdreq | cpu_wrreq;
  assign cpu_busy         = (state != S_IDLE) | (req & ~hit);

  function automatic logic [ADDRBITS-1:0] line_addr(input logic [TAGBITS-1:0] t,
                                                    input logic [LINEBITS-1:0] w);
    return {t, w, 2'b00};
  endfunction

  // Tag compare across all ways; tags are unique among valid ways so at most one hits
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w] && tag_q[w] == addr_tag) begin
        hit     = 1'b1;
        hit_way = WIDX'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the least recently used (oldest age)
  always_comb begin
    vict_c     = '0;
    vict_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vict_found && !valid_q[w]) begin
        vict_c     = WIDX'(w);
        vict_found = 1'b1;
      end
    end
    if (!vict_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w] == AW'(WAYS - 1)) vict_c = WIDX'(w);
      end
    end
  end

  // Flush scan: next dirty way at or above the scan pointer
  always_comb begin
    fl_found = 1'b0;
    fl_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!fl_found && w >= int'(fl_scan) && valid_q[w] && dirty_q[w]) begin
        fl_found = 1'b1;
        fl_way   = WIDX'(w);
      end
    end
  end

  // Controller: line state, LRU ages, sequencer FSM and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      victim        <= '0;
      req_tag       <= '0;
      flushing      <= 1'b0;
      fl_scan       <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      cpu_out       <= '0;
      cpu_out_valid <= 1'b0;
      flush_done    <= 1'b0;
      mem_rdreq     <= 1'b0;
      mem_wrreq     <= 1'b0;
      mem_addr      <= '0;
      mem_out       <= '0;
      for (int w = 0; w < WAYS; w++) begin
        tag_q[w] <= '0;
        age_q[w] <= AW'(w);
      end
    end else begin
      cpu_out_valid <= 1'b0;
      flush_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              if (cpu_wrreq) begin
                dirty_q[hit_way] <= 1'b1;
              end else begin
                cpu_out       <= data_q[hit_way][addr_word];
                cpu_out_valid <= 1'b1;
              end
              for (int v = 0; v < WAYS; v++) begin
                if (WIDX'(v) == hit_way) age_q[v] <= '0;
                else if (age_q[v] < age_q[hit_way]) age_q[v] <= age_q[v] + 1'b1;
              end
            end else begin
              victim   <= vict_c;
              req_tag  <= addr_tag;
              cnt      <= '0;
              flushing <= 1'b0;
              if (valid_q[vict_c] && dirty_q[vict_c]) begin
                state     <= S_WB;
                mem_wrreq <= 1'b1;
                mem_addr  <= line_addr(tag_q[vict_c], '0);
                mem_out   <= data_q[vict_c][0];
              end else begin
                state     <= S_FILL;
                mem_rdreq <= 1'b1;
                mem_addr  <= line_addr(addr_tag, '0);
              end
            end
          end else if (flush_req) begin
            state    <= S_FLUSH;
            fl_scan  <= '0;
            flushing <= 1'b1;
          end
        end
        S_WB: begin
          if (mem_valid) begin
            if (cnt == LAST_WORD) begin
              cnt       <= '0;
              mem_wrreq <= 1'b0;
              if (flushing) begin
                dirty_q[victim] <= 1'b0;
                fl_scan         <= {1'b0, victim} + 1'b1;
                state           <= S_FLUSH;
              end else begin
                state     <= S_FILL;
                mem_rdreq <= 1'b1;
                mem_addr  <= line_addr(req_tag, '0);
              end
            end else begin
              cnt      <= cnt + 1'b1;
              mem_addr <= line_addr(tag_q[victim], cnt + 1'b1);
              mem_out  <= data_q[victim][cnt + 1'b1];
            end
          end
        end
        S_FILL: begin
          if (mem_valid) begin
            if (cnt == LAST_WORD) begin
              cnt             <= '0;
              mem_rdreq       <= 1'b0;
              tag_q[victim]   <= req_tag;
              valid_q[victim] <= 1'b1;
              dirty_q[victim] <= 1'b0;
              state           <= S_IDLE;
            end else begin
              cnt      <= cnt + 1'b1;
              mem_addr <= line_addr(req_tag, cnt + 1'b1);
            end
          end
        end
        S_FLUSH: begin
          if (fl_found) begin
            victim    <= fl_way;
            cnt       <= '0;
            state     <= S_WB;
            mem_wrreq <= 1'b1;
            mem_addr  <= line_addr(tag_q[fl_way], '0);
            mem_out   <= data_q[fl_way][0];
          end else begin
            state      <= S_DONE;
            flush_done <= 1'b1;
            flushing   <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line data: byte-lane writes on a write hit, whole words from memory during fill
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req && hit && cpu_wrreq) begin
      for (int b = 0; b < BANKNUM; b++) begin
        if (cpu_byteenable[b]) data_q[hit_way][addr_word][b*8 +: 8] <= cpu_in[b*8 +: 8];
      end
    end else if (state == S_FILL && mem_valid) begin
      data_q[victim][cnt] <= mem_in;
    end
  end

endmodule

// File: tb/tb_dcache_set.sv
// tb/tb_dcache_set.sv - directed self-checking bench for dcache_set
module tb_dcache_set;

  localparam int DB = 32;
  localparam int AB = 32;
  localparam int LB = 5;
  localparam int NW = 4;
  localparam int BN = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AB-1:0] cpu_addr;
  logic          cpu_rdreq;
  logic          cpu_wrreq;
  logic [DB-1:0] cpu_in;
  logic [BN-1:0] cpu_byteenable;
  logic [DB-1:0] cpu_out;
  logic          cpu_out_valid;
  logic          cpu_busy;
  logic [AB-1:0] mem_addr;
  logic          mem_rdreq;
  logic          mem_wrreq;
  logic [DB-1:0] mem_out;
  logic [DB-1:0] mem_in;
  logic          mem_valid;
  logic          flush_req;
  logic          flush_done;

  always #5 clk = ~clk;

  dcache_set #(.DATABITS(DB), .ADDRBITS(AB), .LINEBITS(LB), .WAYS(NW), .BANKNUM(BN)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_rdreq(cpu_rdreq), .cpu_wrreq(cpu_wrreq),
    .cpu_in(cpu_in), .cpu_byteenable(cpu_byteenable),
    .cpu_out(cpu_out), .cpu_out_valid(cpu_out_valid), .cpu_busy(cpu_busy),
    .mem_addr(mem_addr), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
    .mem_out(mem_out), .mem_in(mem_in), .mem_valid(mem_valid),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Memory agent: answers beats, logs accepted fill/writeback beats, watches gap stability
  bit          gap_mode = 1'b0;
  bit          phase    = 1'b1;
  bit          have_gap = 1'b0;
  logic        agent_v;
  logic [31:0] gap_addr;
  int          gap_bad  = 0;
  logic [31:0] fill_q[$];
  logic [31:0] wb_a[$];
  logic [31:0] wb_d[$];

  always @(negedge clk) begin
    if (reset_n && (mem_rdreq || mem_wrreq)) begin
      agent_v = gap_mode ? phase : 1'b1;
      phase   = ~phase;
      if (agent_v) begin
        if (have_gap && mem_addr !== gap_addr) gap_bad++;
        have_gap = 1'b0;
        if (mem_rdreq) fill_q.push_back(mem_addr);
        else begin
          wb_a.push_back(mem_addr);
          wb_d.push_back(mem_out);
        end
      end else begin
        gap_addr = mem_addr;
        have_gap = 1'b1;
      end
    end else begin
      agent_v  = 1'b0;
      phase    = 1'b1;
      have_gap = 1'b0;
    end
    mem_valid = agent_v;
    mem_in    = mw(mem_addr);
  end

  task automatic clear_logs();
    fill_q.delete();
    wb_a.delete();
    wb_d.delete();
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    @(negedge clk);
    clear_logs();
    cpu_addr  = a;
    cpu_rdreq = 1'b1;
    lat = -1;
    d   = '0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (cpu_out_valid) begin
        lat = i;
        d   = cpu_out;
        break;
      end
    end
    cpu_rdreq = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int lat);
    @(negedge clk);
    cpu_addr       = a;
    cpu_in         = d;
    cpu_byteenable = be;
    cpu_wrreq      = 1'b1;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!cpu_busy) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cpu_wrreq = 1'b0;
  endtask

  task automatic do_flush(output int cyc);
    @(negedge clk);
    clear_logs();
    flush_req = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (flush_done) begin
        cyc = i;
        break;
      end
    end
    flush_req = 1'b0;
    @(negedge clk);
    chk("flush_done_one_pulse", {31'b0, flush_done}, 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] e;
  int          lat;
  bit          seen;

  initial begin
    reset_n = 1'b0; cpu_addr = '0; cpu_rdreq = 1'b0; cpu_wrreq = 1'b0;
    cpu_in = '0; cpu_byteenable = '0; flush_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cpu_out", cpu_out, 32'd0);
    chk("rst_cpu_out_valid", {31'b0, cpu_out_valid}, 32'd0);
    chk("rst_flush_done", {31'b0, flush_done}, 32'd0);
    chk("rst_mem_rdreq", {31'b0, mem_rdreq}, 32'd0);
    chk("rst_mem_wrreq", {31'b0, mem_wrreq}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_out", mem_out, 32'd0);
    chk("rst_cpu_busy", {31'b0, cpu_busy}, 32'd0);

    // clean miss into way 0
    cpu_read(32'h1000, rd, lat);
    chk("miss1_lat", lat, 34);
    chk("miss1_data", rd, mw(32'h1000));
    chk("miss1_fill_cnt", fill_q.size(), 32);
    chk("miss1_fill_first", qat(fill_q, 0), 32'h1000);
    chk("miss1_fill_last", qat(fill_q, 31), 32'h107C);
    chk("miss1_wb_cnt", wb_a.size(), 0);

    // partial write hit then read back
    cpu_write(32'h1004, 32'hDEADBEEF, 4'b0011, lat);
    chk("wr_hit_lat", lat, 0);
    cpu_read(32'h1004, rd, lat);
    e = mw(32'h1004);
    e[15:0] = 16'hBEEF;
    chk("rd_after_wr_lat", lat, 1);
    chk("rd_after_wr_data", rd, e);

    // fill remaining ways with B, C, D
    for (int k = 2; k <= 4; k++) begin
      cpu_read(32'h1000 * k, rd, lat);
      chk($sformatf("fill_way_lat_%0d", k), lat, 34);
    end
    cpu_read(32'h1000, rd, lat);
    chk("touch_a_lat", lat, 1);

    // miss E evicts clean LRU B without writeback
    cpu_read(32'h5000, rd, lat);
    chk("miss_e_lat", lat, 34);
    chk("miss_e_wb_cnt", wb_a.size(), 0);
    cpu_read(32'h4000, rd, lat);
    chk("touch_d_lat", lat, 1);
    cpu_read(32'h3000, rd, lat);
    chk("touch_c_lat", lat, 1);

    // miss F evicts dirty A: writeback then fill
    cpu_read(32'h6000, rd, lat);
    chk("miss_f_lat", lat, 66);
    chk("miss_f_data", rd, mw(32'h6000));
    chk("miss_f_wb_cnt", wb_a.size(), 32);
    chk("miss_f_wb_first", qat(wb_a, 0), 32'h1000);
    chk("miss_f_wb_last", qat(wb_a, 31), 32'h107C);
    chk("miss_f_wb_word1", qat(wb_d, 1), e);
    chk("miss_f_fill_first", qat(fill_q, 0), 32'h6000);

    // dirty ways 0 (F) and 2 (C), then flush
    cpu_write(32'h6008, 32'h11223344, 4'b1111, lat);
    chk("wr_f_lat", lat, 0);
    cpu_write(32'h300C, 32'hCAFEF00D, 4'b1100, lat);
    chk("wr_c_lat", lat, 0);
    do_flush(lat);
    chk("flush1_done_seen", {31'b0, lat > 0}, 32'd1);
    chk("flush1_wb_cnt", wb_a.size(), 64);
    chk("flush1_way0_addr", qat(wb_a, 0), 32'h6000);
    chk("flush1_way0_word2", qat(wb_d, 2), 32'h11223344);
    chk("flush1_way2_addr", qat(wb_a, 32), 32'h3000);
    e = mw(32'h300C);
    e[31:16] = 16'hCAFE;
    chk("flush1_way2_word3", qat(wb_d, 35), e);

    // nothing dirty: immediate done
    do_flush(lat);
    chk("flush2_cycles", lat, 2);
    chk("flush2_wb_cnt", wb_a.size(), 0);

    // lines stay valid after flush
    cpu_read(32'h6008, rd, lat);
    chk("post_flush_hit_lat", lat, 1);
    chk("post_flush_hit_data", rd, 32'h11223344);

    // B was evicted earlier; now evicts clean E
    cpu_read(32'h2000, rd, lat);
    chk("b_remiss_lat", lat, 34);
    chk("b_remiss_wb_cnt", wb_a.size(), 0);

    // fill with alternating mem_valid gaps
    gap_mode = 1'b1;
    cpu_read(32'h7010, rd, lat);
    gap_mode = 1'b0;
    chk("gap_lat", lat, 65);
    chk("gap_data", rd, mw(32'h7010));
    chk("gap_fill_cnt", fill_q.size(), 32);
    chk("gap_fill_last", qat(fill_q, 31), 32'h707C);
    chk("gap_addr_stable", gap_bad, 0);

    // reset in the middle of a fill
    @(negedge clk);
    clear_logs();
    cpu_addr  = 32'h8000;
    cpu_rdreq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fill_q.size() >= 10) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_mid_fill_reached", {31'b0, seen}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mem_rdreq", {31'b0, mem_rdreq}, 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_cpu_out", cpu_out, 32'd0);
    chk("rst_mid_mem_wrreq", {31'b0, mem_wrreq}, 32'd0);
    cpu_rdreq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cpu_read(32'h8000, rd, lat);
    chk("post_rst_miss_lat", lat, 34);
    chk("post_rst_miss_data", rd, mw(32'h8000));
    cpu_read(32'h6008, rd, lat);
    chk("post_rst_old_line_lat", lat, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
